// File: rtl/coin_acceptor.sv
// coin_acceptor: front end for vending_mac's coin input.
// Each raw coin sensor passes through a 2-flop synchroniser and a debouncer.
// A rising edge on a debounced level becomes one coin event. Events are queued
// in a small FIFO, and coins are delivered one per cycle whenever hold is low.
//
// Ports:
//   clk         system clock; all logic runs on its rising edge
//   rst         synchronous, active-high reset
//   coin5_raw   asynchronous, bouncy 5-unit sensor (high while a coin is present)
//   coin10_raw  asynchronous, bouncy 10-unit sensor
//   hold        1 = stall delivery; the queued coins are kept
//   coin_code   registered code: 00 idle, 01 five, 10 ten (never 11)
//   coin_reject registered one-cycle pulse when a coin event is dropped on a full queue
//   fifo_count  number of events currently queued
module coin_acceptor #(
    parameter int DEB_CYCLES = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             coin5_raw,
    input  logic             coin10_raw,
    input  logic             hold,
    output logic [1:0]       coin_code,
    output logic             coin_reject,
    output logic [CNT_W-1:0] fifo_count
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    // Channel index 0 is the 5-unit sensor and index 1 is the 10-unit sensor.
    logic [1:0]    raw;
    logic [1:0]    sync1, sync2;
    logic [1:0]    deb, deb_d;
    logic [DW-1:0] deb_cnt [2];
    logic [1:0]    ev;

    logic [1:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;

    logic           pop;
    logic [CNT_W:0] free;
    logic           acc5, acc10, drop;
    logic [CNT_W-1:0] npush;

    assign raw        = {coin10_raw, coin5_raw};
    assign ev         = deb & ~deb_d;
    assign fifo_count = count;

    // Synchroniser, debounce and edge-detect history.
    // deb_cnt counts consecutive synchronised samples that disagree with the
    // debounced level. The DEB_CYCLES-th disagreeing sample flips the level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_d <= '0;
            for (int unsigned ch = 0; ch < 2; ch++) begin
                deb_cnt[ch] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_d <= deb;
            for (int unsigned ch = 0; ch < 2; ch++) begin
                if (sync2[ch] != deb[ch]) begin
                    if (deb_cnt[ch] == DW'(DEB_CYCLES - 1)) begin
                        deb[ch]     <= ~deb[ch];
                        deb_cnt[ch] <= '0;
                    end else begin
                        deb_cnt[ch] <= deb_cnt[ch] + 1'b1;
                    end
                end else begin
                    deb_cnt[ch] <= '0;
                end
            end
        end
    end

    // Slot allocation. A pop in the same cycle frees a slot. The 5-unit event
    // claims a slot before the 10-unit event does.
    always_comb begin
        pop   = 1'b0;
        free  = '0;
        acc5  = 1'b0;
        acc10 = 1'b0;
        drop  = 1'b0;
        npush = '0;

        pop   = !hold && (count != '0);
        free  = (CNT_W+1)'(FIFO_DEPTH) - {1'b0, count} + {{CNT_W{1'b0}}, pop};
        acc5  = ev[0] && (free != '0);
        acc10 = ev[1] && (acc5 ? (free >= (CNT_W+1)'(2)) : (free != '0));
        drop  = (ev[0] && !acc5) || (ev[1] && !acc10);
        npush = CNT_W'(acc5) + CNT_W'(acc10);
    end

    // Queue storage has no reset. Only the entries between the pointers are meaningful.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (acc5) begin
                mem[wr_ptr] <= 2'b01;
            end
            if (acc10) begin
                mem[acc5 ? wr_ptr + 1'b1 : wr_ptr] <= 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            coin_code   <= 2'b00;
            coin_reject <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr + PW'(npush);
            rd_ptr      <= rd_ptr + PW'(pop);
            count       <= count + npush - CNT_W'(pop);
            coin_code   <= pop ? mem[rd_ptr] : 2'b00;
            coin_reject <= drop;
        end
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// Randomised and directed bench for coin_acceptor, checked by a scoreboard.
// The reference model works from the behavioural rules:
//   - a sensor level is accepted once it has been seen for DEB samples in a row,
//     after the synchroniser delay;
//   - each accepted rising level yields one coin;
//   - coins go into a bounded queue that drains one per cycle unless hold is set.
module tb_coin_acceptor;

    localparam int DEB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin5_raw = 1'b0;
    logic       coin10_raw = 1'b0;
    logic       hold = 1'b0;
    logic [1:0] coin_code;
    logic       coin_reject;
    logic [2:0] fifo_count;

    coin_acceptor #(.DEB_CYCLES(DEB), .FIFO_DEPTH(DEPTH), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .coin5_raw(coin5_raw), .coin10_raw(coin10_raw),
        .hold(hold), .coin_code(coin_code), .coin_reject(coin_reject),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit       h5[$], h10[$];   // last DEB+2 raw samples, oldest first
    bit       lvl5, lvl10;     // model debounced levels
    bit       pend5, pend10;   // coin seen last edge, enters queue this edge
    bit [1:0] mq[$];           // model coin queue
    bit [1:0] exp_q[$];        // scoreboard: coins expected on coin_code
    bit       exp_rej;
    int       exp_cnt;
    bit       m_pop, m_drop, f5, f10;
    int       m_free;

    // The window covers the samples from DEB+1 edges ago up to 2 edges ago,
    // which accounts for the synchroniser delay.
    function automatic bit stable_other(input bit h[$], input bit lvl);
        for (int i = 0; i < DEB; i++) if (h[i] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            h5 = {}; h10 = {};
            for (int i = 0; i < DEB + 2; i++) begin h5.push_back(1'b0); h10.push_back(1'b0); end
            lvl5 = 0; lvl10 = 0; pend5 = 0; pend10 = 0;
            mq.delete(); exp_q.delete();
            exp_rej = 0; exp_cnt = 0;
        end else begin
            m_pop = !hold && (mq.size() > 0);
            if (m_pop) exp_q.push_back(mq.pop_front());
            m_free = DEPTH - mq.size();
            m_drop = 0;
            if (pend5) begin
                if (m_free > 0) begin mq.push_back(2'b01); m_free--; end else m_drop = 1;
            end
            if (pend10) begin
                if (m_free > 0) begin mq.push_back(2'b10); m_free--; end else m_drop = 1;
            end
            exp_rej = m_drop;
            exp_cnt = mq.size();

            void'(h5.pop_front());  h5.push_back(coin5_raw);
            void'(h10.pop_front()); h10.push_back(coin10_raw);
            f5  = stable_other(h5, lvl5);
            f10 = stable_other(h10, lvl10);
            pend5  = f5 && !lvl5;
            pend10 = f10 && !lvl10;
            if (f5)  lvl5  = ~lvl5;
            if (f10) lvl10 = ~lvl10;
        end
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (coin_code != 2'b00) begin
                if (exp_q.size() == 0) chk("unexpected_coin", int'(coin_code), 0);
                else chk("coin_code", int'(coin_code), int'(exp_q.pop_front()));
            end else if (exp_q.size() != 0) begin
                chk("missed_coin", 0, int'(exp_q.pop_front()));
            end
            chk("coin_reject", int'(coin_reject), int'(exp_rej));
            chk("fifo_count", int'(fifo_count), exp_cnt);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic coin5(input int len);
        coin5_raw = 1'b1; idle(len); coin5_raw = 1'b0; idle(10);
    endtask

    int r5, r10, rh;

    initial begin
        idle(3);
        rst = 1'b0;
        idle(2);

        // a single 5-unit coin
        coin5_raw = 1'b1; idle(20); coin5_raw = 1'b0; idle(12);

        // bouncy 10-unit sensor that settles high
        for (int i = 0; i < 10; ) begin
            int p = $urandom_range(1, 3);
            coin10_raw = ~coin10_raw;
            idle(p);
            i += p;
        end
        coin10_raw = 1'b1; idle(20); coin10_raw = 1'b0; idle(12);

        // both sensors rise together
        coin5_raw = 1'b1; coin10_raw = 1'b1; idle(15);
        coin5_raw = 1'b0; coin10_raw = 1'b0; idle(12);

        // five coins while held: the fifth is rejected
        hold = 1'b1;
        repeat (5) coin5(8);
        idle(4);
        hold = 1'b0; idle(10);

        // full queue, and a new coin is pushed in the same cycle as the first pop
        hold = 1'b1;
        repeat (4) coin5(8);
        coin5_raw = 1'b1;
        idle(6);
        hold = 1'b0;
        idle(8); coin5_raw = 1'b0; idle(15);

        // reset while three coins are queued
        hold = 1'b1;
        repeat (3) coin5(8);
        idle(3);
        rst = 1'b1; idle(1); rst = 1'b0; hold = 1'b0;
        idle(12);

        // randomised phase
        r5 = 0; r10 = 0; rh = 0;
        for (int c = 0; c < 4000; c++) begin
            if (r5 == 0) begin
                coin5_raw = $urandom_range(0, 1);
                r5 = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 25);
            end
            if (r10 == 0) begin
                coin10_raw = $urandom_range(0, 1);
                r10 = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 25);
            end
            if (rh == 0) begin
                hold = ($urandom_range(0, 2) == 0);
                rh = $urandom_range(1, 40);
            end
            rst = ($urandom_range(0, 499) == 0);
            r5--; r10--; rh--;
            idle(1);
        end
        rst = 1'b0; hold = 1'b0; coin5_raw = 1'b0; coin10_raw = 1'b0;
        idle(30);
        chk("drain_count", int'(fifo_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
